// File: rtl/gf2m_pkg.sv
// Shared GF(2^m) arithmetic definitions: default field parameters,
// the B-163 reduction polynomial and the multiplier FSM encoding.
package gf2m_pkg;

  localparam int DEFAULT_M = 163;
  localparam int DEFAULT_D = 8;

  // f(x) = x^163 + x^7 + x^6 + x^3 + 1, with the x^163 term left implicit
  localparam logic [162:0] B163_POLY = 163'hC9;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One digit-serial iteration: acc_next = (acc * x^D + a * digit) mod f(x),
// with f(x) = x^M + p(x). Purely combinational.
module gf2m_digit_step #(
  parameter int M = 163,
  parameter int D = 8
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] a,
  input  logic [D-1:0] digit,
  input  logic [M-1:0] p,
  output logic [M-1:0] acc_next
);

  // Horner over the digit bits, MSB first: every bit costs one multiply-by-x
  // with its reduction, then a conditional add of a. Because a is already
  // reduced, the sum never leaves the field and needs no extra reduction.
  always_comb begin
    logic [M-1:0] r;
    r = acc;
    for (int j = D - 1; j >= 0; j--) begin
      r = (r << 1) ^ (r[M-1] ? p : '0) ^ (digit[j] ? a : '0);
    end
    acc_next = r;
  end

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) polynomial-basis multiplier, C = A*B mod (x^M + P).
// Consumes one D-bit digit of B per clock, MSB digit first.
module gf2m_digit_serial_mult
  import gf2m_pkg::*;
#(
  parameter int M = DEFAULT_M,
  parameter int D = DEFAULT_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic [M-1:0] P,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] C
);

  localparam int N     = ceil_div(M, D);
  localparam int W     = N * D;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [M-1:0]     acc_reg;
  logic [M-1:0]     a_reg;
  logic [M-1:0]     p_reg;
  logic [W-1:0]     b_reg;
  logic [M-1:0]     c_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [M-1:0]     acc_next;
  logic [D-1:0]     digit;

  // b_reg shifts left each step, so the current digit always sits on top
  assign digit = b_reg[W-1 -: D];

  gf2m_digit_step #(
    .M (M),
    .D (D)
  ) u_step (
    .acc      (acc_reg),
    .a        (a_reg),
    .digit    (digit),
    .p        (p_reg),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      a_reg     <= '0;
      p_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= A;
            p_reg     <= P;
            b_reg     <= W'(B);
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          b_reg   <= b_reg << D;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(N - 1)) begin
            c_reg     <= acc_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign C    = c_reg;

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Directed and randomised checks of the digit-serial GF(2^m) multiplier,
// default B-163 instance plus a small GF(2^8) instance with D=3.
module tb_gf2m_digit_serial_mult;

  logic         clk;
  logic         rst;

  logic         start;
  logic [162:0] a_in;
  logic [162:0] b_in;
  logic [162:0] p_in;
  logic         busy;
  logic         done;
  logic [162:0] c_out;

  logic         s_start;
  logic [7:0]   s_a;
  logic [7:0]   s_b;
  logic [7:0]   s_p;
  logic         s_busy;
  logic         s_done;
  logic [7:0]   s_c;

  int n_cmp = 0;
  int n_err = 0;

  gf2m_digit_serial_mult dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .P     (p_in),
    .busy  (busy),
    .done  (done),
    .C     (c_out)
  );

  gf2m_digit_serial_mult #(.M(8), .D(3)) dut_small (
    .clk   (clk),
    .rst   (rst),
    .start (s_start),
    .A     (s_a),
    .B     (s_b),
    .P     (s_p),
    .busy  (s_busy),
    .done  (s_done),
    .C     (s_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [162:0] got, input logic [162:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: full 325-bit carry-less product, then long-division reduction
  function automatic logic [162:0] ref_mul(input logic [162:0] a, input logic [162:0] b,
                                           input logic [162:0] p);
    logic [324:0] prod;
    logic [163:0] f;
    prod = '0;
    f = {1'b1, p};
    for (int i = 0; i < 163; i++)
      if (b[i]) prod = prod ^ (325'(a) << i);
    for (int k = 324; k >= 163; k--)
      if (prod[k]) prod = prod ^ (325'(f) << (k - 163));
    return prod[162:0];
  endfunction

  function automatic logic [162:0] rand163();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[162:0];
  endfunction

  // Start one operation; report result, cycles to done and cycles with busy high
  task automatic run_op(input logic [162:0] a, input logic [162:0] b,
                        output logic [162:0] c, output int lat, output int busy_cycles);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = rand163();
    b_in  = rand163();
    lat = 0;
    busy_cycles = 0;
    while (1) begin
      if (busy) busy_cycles++;
      if (done || lat >= 100) break;
      @(posedge clk);
      #1;
      lat++;
    end
    c = c_out;
  endtask

  logic [162:0] c_res;
  logic [162:0] x1, y1, x2, y2, first_c;
  int lat, bcyc, done_cnt;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    p_in = 163'hC9;
    s_start = 1'b0;
    s_a = '0;
    s_b = '0;
    s_p = 8'h1B;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 163'(busy), 163'd0);
    check("reset_done", 163'(done), 163'd0);
    check("reset_c", c_out, '0);
    check("reset_small_c", 163'(s_c), '0);
    @(negedge clk);
    rst = 1'b0;

    // GF(2^8) AES field: 0x57 * 0x83 = 0xC1, N = ceil(8/3) = 3
    @(negedge clk);
    s_a = 8'h57;
    s_b = 8'h83;
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    lat = 0;
    while (!s_done && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("small_lat", 163'(lat), 163'd3);
    check("small_c", 163'(s_c), 163'hC1);
    $display("small: A=57 B=83 C=%h lat=%0d", s_c, lat);

    // x * x^162 = x^163 = P
    run_op(163'h2, 163'd1 << 162, c_res, lat, bcyc);
    check("x163_c", c_res, 163'hC9);
    check("x163_lat", 163'(lat), 163'd21);
    check("x163_busy", 163'(bcyc), 163'd21);
    $display("x*x^162: C=%h lat=%0d", c_res, lat);

    run_op(163'h1, 163'h1, c_res, lat, bcyc);
    check("one_c", c_res, 163'h1);
    $display("1*1: C=%h", c_res);

    x1 = rand163();
    run_op(163'h0, x1, c_res, lat, bcyc);
    check("zero_c", c_res, '0);
    $display("0*B: C=%h", c_res);

    // all-ones operands exercise every reduction path
    run_op({163{1'b1}}, {163{1'b1}}, c_res, lat, bcyc);
    check("ones_c", c_res, ref_mul({163{1'b1}}, {163{1'b1}}, 163'hC9));
    $display("ones: C=%h", c_res);

    for (int i = 0; i < 1000; i++) begin
      x2 = rand163();
      y2 = rand163();
      run_op(x2, y2, c_res, lat, bcyc);
      check("rand_c", c_res, ref_mul(x2, y2, 163'hC9));
      check("rand_busy", 163'(bcyc), 163'd21);
      if (i < 4) $display("rand %0d: C=%h lat=%0d busy=%0d", i, c_res, lat, bcyc);
    end

    // start re-asserted while busy must be ignored
    x1 = rand163();
    y1 = rand163();
    x2 = rand163();
    y2 = rand163();
    @(negedge clk);
    a_in = x1;
    b_in = y1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    a_in = x2;
    b_in = y2;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    start = 1'b0;
    first_c = '0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        first_c = c_out;
      end
    end
    check("midstart_dones", 163'(done_cnt), 163'd1);
    check("midstart_c", first_c, ref_mul(x1, y1, 163'hC9));
    $display("mid-start: dones=%0d C=%h", done_cnt, first_c);

    // start held through the done cycle: second op accepted at the done edge
    x1 = rand163();
    y1 = rand163();
    x2 = rand163();
    y2 = rand163();
    @(negedge clk);
    a_in = x1;
    b_in = y1;
    start = 1'b1;
    @(posedge clk);
    #1;
    a_in = rand163();
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_lat1", 163'(lat), 163'd21);
    first_c = c_out;
    check("b2b_c1", first_c, ref_mul(x1, y1, 163'hC9));
    a_in = x2;
    b_in = y2;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy", 163'(busy), 163'd1);
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 20) check("b2b_hold", c_out, first_c);
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_lat2", 163'(lat), 163'd21);
    check("b2b_c2", c_out, ref_mul(x2, y2, 163'hC9));
    $display("back-to-back: C1=%h C2=%h", first_c, c_out);

    // rst at RUN cycle 10 aborts with no done pulse
    @(negedge clk);
    a_in = rand163();
    b_in = rand163();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy", 163'(busy), 163'd0);
    check("rst_done", 163'(done), 163'd0);
    check("rst_c", c_out, '0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("rst_nodone", 163'(done_cnt), 163'd0);
    x1 = rand163();
    y1 = rand163();
    run_op(x1, y1, c_res, lat, bcyc);
    check("rst_fresh_c", c_res, ref_mul(x1, y1, 163'hC9));
    check("rst_fresh_lat", 163'(lat), 163'd21);
    $display("after reset: C=%h lat=%0d", c_res, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
